priority_req_queue: RTL and testbench
=====================================

PRIORITY_REQ_QUEUE -- requirements
Module: priority_req_queue

Interface
REQ-001 The block SHALL have parameter NPORT, default 4, meaning the number of requester ports, equal to the arbiter width.
REQ-002 The block SHALL have parameter DW, default 8, meaning the payload width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the entries per port queue (power of 2, >=2).
REQ-004 The block SHALL have port clk_i, input, 1 bit: single clock, all logic on the rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port push_i, input, NPORT bits: per-port push strobe.
REQ-007 The block SHALL have port push_data_i, input, NPORT*DW bits: port p payload at bits [p*DW +: DW].
REQ-008 The block SHALL have port full_o, output, NPORT bits: port queue holds DEPTH entries.
REQ-009 The block SHALL have port req_o, output, NPORT bits: request vector driven to the priority arbiter req_i.
REQ-010 The block SHALL have port gnt_i, input, NPORT bits: one-hot registered grant from the arbiter, arriving one cycle after the req_o it answers.
REQ-011 The block SHALL have port out_valid_o, output, 1 bit: one-cycle pulse marking a dequeued entry.
REQ-012 The block SHALL have port out_data_o, output, DW bits: dequeued payload.
REQ-013 The block SHALL have port out_port_o, output, log2(NPORT) bits: index of the source port.
REQ-014 The block SHALL have port err_o, output, 2 bits: sticky flags; bit0 push-while-full, bit1 grant-on-empty or non-one-hot grant.

Function
REQ-015 Each port SHALL keep an independent FIFO with count 0..DEPTH and wrapping read/write pointers.
REQ-016 A push when the port count < DEPTH SHALL be written at the next edge; a push when the port count == DEPTH SHALL be dropped and SHALL set err_o[0].
REQ-017 full_o[p] SHALL be combinational from the current count (count==DEPTH); a same-cycle pop SHALL NOT make room for a push in that cycle.
REQ-018 A pop on port p SHALL occur when gnt_i[p]=1, gnt_i is one-hot, and count_p>0.
REQ-019 A grant to an empty port SHALL be ignored and SHALL set err_o[1]; a non-one-hot non-zero grant SHALL pop nothing and SHALL set err_o[1].
REQ-020 req_o[p] SHALL equal (count_p>=2) OR (count_p==1 AND NOT gnt_i[p]); the last entry is therefore never re-requested while its grant is in flight.
REQ-021 A simultaneous push and pop on the same port (not full) SHALL leave the count unchanged and keep data order FIFO.
REQ-022 A pop SHALL register the head entry so that out_valid_o=1, out_data_o=head and out_port_o=p appear the cycle after gnt_i, giving a latency of 1.
REQ-023 out_valid_o SHALL be 0 in every cycle not following a pop.
REQ-024 There SHALL be no output backpressure: downstream SHALL accept every out_valid_o pulse.
REQ-025 Pointer and count arithmetic SHALL wrap modulo DEPTH, with count kept in log2(DEPTH)+1 bits.

Reset
REQ-026 While rst_i=1 at a clock edge, all counts and pointers, out_valid_o and err_o SHALL clear to 0, and out_data_o and out_port_o SHALL be 0.
REQ-027 After reset, req_o and full_o SHALL be 0 (follows from count=0).
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; pushes and grants during reset SHALL be ignored.

Structure
REQ-029 NPORT, DW and DEPTH defaults and the err_o bit indices SHALL live in shared package priority_arb_pkg.
REQ-030 One sub-module, req_fifo (DW, DEPTH; push, pop, head, count), SHALL be instantiated NPORT times.
REQ-031 The output register, error logic and req_o logic SHALL live in the top level.

Verification (bench pairs the block with the priority arbiter, port 0 highest priority)
REQ-032 Reset, then push port2 data 0xA5 -> req_o=4'b0100 next cycle; gnt 1 cycle later; out_valid_o=1, out_data_o=0xA5, out_port_o=2 one cycle after gnt; req_o[2]=0 from the gnt cycle onward.
REQ-033 Push 0x11 to port3 and 0x22 to port0 in the same cycle -> output order port0 (0x22) then port3 (0x11); exactly 2 out_valid_o pulses.
REQ-034 Push 5 entries into port1 with no grants -> full_o[1]=1 after the 4th, 5th dropped, err_o=2'b01; draining yields exactly 4 entries in order.
REQ-035 Force gnt_i=4'b0010 while port1 is empty -> no out_valid_o, counts unchanged, err_o[1]=1; gnt_i=4'b0011 -> no pop, err_o[1]=1.
REQ-036 Port1 count=2 with continuous push and grant each cycle -> count stays 2 and output data is in push order.
REQ-037 Assert rst_i with 3 entries queued -> next cycle counts=0, req_o=0, err_o=0; no stale output after release.

Source files
------------

// File: rtl/priority_arb_pkg.sv
// Shared defaults and error-flag bit positions for the priority request queue.
package priority_arb_pkg;
  localparam int NPORT_DEF = 4;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  localparam int ERR_FULL = 0;
  localparam int ERR_GNT  = 1;

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction
endpackage

// File: rtl/priority_req_queue_if.sv
// Request/grant link between the queue block and its priority arbiter.
interface priority_req_queue_if
  import priority_arb_pkg::*;
#(
  parameter int NPORT = NPORT_DEF
) (
  input logic clk_i
);
  logic [NPORT-1:0] req;
  logic [NPORT-1:0] gnt;

  modport master (output req, input gnt);
  modport slave  (input clk_i, input req, output gnt);
endinterface

// File: rtl/priority_req_queue_req_fifo.sv
// Per-port circular FIFO; pushes are refused when full, pops when empty.
module req_fifo
  import priority_arb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [CW-1:0] count_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    push_ok = push_i && (count_q != CW'(DEPTH));
    pop_ok  = pop_i && (count_q != '0);
    wptr_d  = wptr_q + AW'(push_ok);
    rptr_d  = rptr_q + AW'(pop_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/priority_req_queue.sv
// Per-port request queues feeding a registered-grant priority arbiter.
module priority_req_queue
  import priority_arb_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = (NPORT > 1) ? $clog2(NPORT) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NPORT-1:0]  push_i,
  input  logic [NPORT*DW-1:0] push_data_i,
  output logic [NPORT-1:0]  full_o,
  output logic [NPORT-1:0]  req_o,
  input  logic [NPORT-1:0]  gnt_i,
  output logic              out_valid_o,
  output logic [DW-1:0]     out_data_o,
  output logic [PW-1:0]     out_port_o,
  output logic [1:0]        err_o
);
  logic [DW-1:0]    head [NPORT];
  logic [CW-1:0]    cnt  [NPORT];
  logic [NPORT-1:0] pop, empty;
  logic             gnt_1h;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [PW-1:0] out_port_q, out_port_d;
  logic [1:0]    err_q, err_d;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    req_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push_i[p]),
      .push_data_i (push_data_i[p*DW +: DW]),
      .pop_i       (pop[p]),
      .head_o      (head[p]),
      .count_o     (cnt[p])
    );
  end

  // A last entry with its grant in flight is not requested again.
  always_comb begin
    gnt_1h = is_onehot(32'(gnt_i));
    for (int p = 0; p < NPORT; p++) begin
      empty[p]  = (cnt[p] == '0);
      full_o[p] = (cnt[p] == CW'(DEPTH));
      pop[p]    = gnt_1h && gnt_i[p] && !empty[p];
      req_o[p]  = (cnt[p] >= CW'(2)) ||
                  ((cnt[p] == CW'(1)) && !gnt_i[p]);
    end
  end

  always_comb begin
    out_valid_d = |pop;
    out_data_d  = out_data_q;
    out_port_d  = out_port_q;
    for (int p = 0; p < NPORT; p++) begin
      if (pop[p]) begin
        out_data_d = head[p];
        out_port_d = PW'(p);
      end
    end
    err_d = err_q;
    if (|(push_i & full_o)) err_d[ERR_FULL] = 1'b1;
    if (((gnt_i != '0) && !gnt_1h) || |(gnt_i & empty))
      err_d[ERR_GNT] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= '0;
      err_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_port_q  <= out_port_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_port_o  = out_port_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_priority_req_queue.sv
// Bench: queue block paired with a port-0-first registered arbiter,
// checked cycle by cycle against per-port queue model.
module tb_priority_req_queue;
  import priority_arb_pkg::*;

  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             rst_i;
  logic [NP-1:0]    push_i;
  logic [NP*DW-1:0] push_data_i;
  logic [NP-1:0]    full_o;
  logic             out_valid_o;
  logic [DW-1:0]    out_data_o;
  logic [1:0]       out_port_o;
  logic [1:0]       err_o;

  priority_req_queue_if #(.NPORT(NP)) aif (.clk_i(clk_i));

  priority_req_queue #(
    .NPORT (NP),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .full_o      (full_o),
    .req_o       (aif.req),
    .gnt_i       (aif.gnt),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_port_o  (out_port_o),
    .err_o       (err_o)
  );

  logic [DW-1:0] mq [NP][$];
  logic [1:0]    m_err;
  logic [NP-1:0] arb_q;
  int            vectors;
  int            miscompares;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [NP-1:0] push,
                      input logic [NP*DW-1:0] pdata,
                      input logic frc, input logic [NP-1:0] fg);
    logic [NP-1:0] gnt, ereq, efull, arb_d;
    int            sz [NP];
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic [1:0]    exp_p;
    gnt         = frc ? fg : arb_q;
    rst_i       = rst;
    push_i      = push;
    push_data_i = pdata;
    aif.gnt     = gnt;
    for (int p = 0; p < NP; p++) begin
      sz[p]    = mq[p].size();
      ereq[p]  = (sz[p] >= 2) || (sz[p] == 1 && !gnt[p]);
      efull[p] = (sz[p] == DEPTH);
    end
    arb_d = '0;
    for (int p = NP - 1; p >= 0; p--)
      if (ereq[p]) arb_d = NP'(1) << p;
    #1;
    chk("req_o", 32'(aif.req), 32'(ereq));
    chk("full_o", 32'(full_o), 32'(efull));
    @(posedge clk_i);
    exp_v = 1'b0;
    exp_d = '0;
    exp_p = '0;
    if (rst) begin
      for (int p = 0; p < NP; p++) mq[p].delete();
      m_err = '0;
      arb_q = '0;
    end else begin
      if (gnt != '0) begin
        if ($countones(gnt) != 1) m_err[1] = 1'b1;
        else begin
          for (int p = 0; p < NP; p++) begin
            if (gnt[p]) begin
              if (sz[p] == 0) m_err[1] = 1'b1;
              else begin
                exp_v = 1'b1;
                exp_d = mq[p].pop_front();
                exp_p = 2'(p);
              end
            end
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (push[p]) begin
          if (sz[p] == DEPTH) m_err[0] = 1'b1;
          else mq[p].push_back(pdata[p*DW +: DW]);
        end
      end
      arb_q = arb_d;
    end
    #1;
    chk("out_valid_o", 32'(out_valid_o), 32'(exp_v));
    chk("err_o", 32'(err_o), 32'(m_err));
    if (exp_v || rst) begin
      chk("out_data_o", 32'(out_data_o), 32'(exp_d));
      chk("out_port_o", 32'(out_port_o), 32'(exp_p));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_err       = '0;
    arb_q       = '0;
    rst_i       = 1'b1;
    push_i      = '0;
    push_data_i = '0;
    aif.gnt     = '0;
    @(posedge clk_i);
    #1;

    // pushes and grants while in reset are ignored
    step(1'b1, 4'b1111, 32'h1234_5678, 1'b1, 4'b0010);
    step(1'b1, 4'b0101, 32'hDEAD_BEEF, 1'b0, '0);

    // single entry on port 2
    step(1'b0, 4'b0100, 32'h00A5_0000, 1'b0, '0);
    idle(4);

    // port 3 and port 0 together: port 0 drains first
    step(1'b0, 4'b1001, 32'h1100_0022, 1'b0, '0);
    idle(6);

    // overfill port 1 with no grants, then drain
    for (int i = 0; i < 5; i++)
      step(1'b0, 4'b0010, 32'(i + 8'h30) << 8, 1'b1, '0);
    idle(8);

    // grant to empty port, then non-one-hot grant
    step(1'b0, '0, '0, 1'b1, 4'b0010);
    step(1'b0, '0, '0, 1'b1, 4'b0011);
    idle(2);

    // steady push+pop on port 1 at count 2
    step(1'b0, 4'b0010, 32'h0000_4000, 1'b1, '0);
    step(1'b0, 4'b0010, 32'h0000_4100, 1'b1, '0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 4'b0010, 32'($urandom_range(255)) << 8, 1'b1, 4'b0010);
    idle(5);

    // reset with entries queued
    step(1'b0, 4'b0111, $urandom(), 1'b1, '0);
    step(1'b1, '0, '0, 1'b0, '0);
    idle(3);

    // random traffic with occasional bad grants and resets
    for (int i = 0; i < 500; i++)
      step(($urandom_range(127) == 0), NP'($urandom() & $urandom()),
           $urandom(), ($urandom_range(7) == 0), NP'($urandom()));
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
